// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, scoreboard entry
// layout and width helpers.
package hazard_pkg;

    // Entry index fields are stored at a fixed width; unused upper bits stay zero.
    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } hz_state_t;

    typedef struct packed {
        logic             vld;
        logic             wr;
        logic [IDX_W-1:0] rd;
        logic             load;
        logic [IDX_W-1:0] rs;
        logic [IDX_W-1:0] rt;
        logic             rs_used;
        logic             rt_used;
    } sb_entry_t;

    function automatic int sel_width(input int stages);
        return $clog2(stages);
    endfunction

    function automatic int cnt_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hz_src_match.sv
// Compares one ID source and one EX source against every scoreboard entry,
// producing a stall request for ID and a forwarding select for EX.
module hz_src_match
    import hazard_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int LOAD_RDY = 2,
    parameter int ALU_RDY  = 1,
    parameter int SW       = 2
) (
    input  sb_entry_t        sb [STAGES],
    input  logic [IDX_W-1:0] id_src,
    input  logic             id_used,
    input  logic [IDX_W-1:0] ex_src,
    input  logic             ex_used,
    output logic             stall_req,
    output logic [SW-1:0]    fwd_sel
);

    logic [STAGES-1:0] id_hit;
    logic [STAGES-1:0] early;
    logic [STAGES-1:1] ex_hit;
    logic [STAGES-1:1] ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_ent
            // A writer in entry gi reaches entry gi+1 when the ID reader enters EX.
            localparam logic LOAD_EARLY = ((gi + 1) < LOAD_RDY);
            localparam logic ALU_EARLY  = ((gi + 1) < ALU_RDY);
            logic writes;

            assign writes      = sb[gi].vld & sb[gi].wr & (sb[gi].rd != '0);
            assign id_hit[gi]  = writes & id_used & (sb[gi].rd == id_src);
            assign early[gi]   = sb[gi].load ? LOAD_EARLY : ALU_EARLY;

            if (gi > 0) begin : g_fwd
                localparam logic LOAD_READY = (gi >= LOAD_RDY);
                localparam logic ALU_READY  = (gi >= ALU_RDY);
                assign ex_hit[gi] = writes & ex_used & (sb[gi].rd == ex_src);
                assign ready[gi]  = sb[gi].load ? LOAD_READY : ALU_READY;
            end
        end
    endgenerate

    assign stall_req = |(id_hit & early);

    // Only the youngest writer holds the current value of the register.
    always_comb begin
        logic found;
        fwd_sel = '0;
        found   = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if (!found && ex_hit[k]) begin
                found = 1'b1;
                if (ready[k]) begin
                    fwd_sel = SW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard controller for the in-order pipeline: stall, flush,
// forwarding selects and the HLT drain sequence.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int REG_W    = 4,
    parameter  int STAGES   = 3,
    parameter  int LOAD_RDY = 2,
    parameter  int ALU_RDY  = 1,
    localparam int SW       = sel_width(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_hlt,
    input  logic             ex_br_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [SW-1:0]    fwd_rs_sel,
    output logic [SW-1:0]    fwd_rt_sel,
    output logic             hlt
);

    localparam int CW = cnt_width(STAGES);

    sb_entry_t     sb_reg [STAGES];
    sb_entry_t     id_entry;
    hz_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          rs_stall, rt_stall, stall;

    always_comb begin
        id_entry         = '0;
        id_entry.vld     = id_valid & ~id_ex_bubble;
        id_entry.wr      = id_wr;
        id_entry.rd      = IDX_W'(id_rd);
        id_entry.load    = id_load;
        id_entry.rs      = IDX_W'(id_rs);
        id_entry.rt      = IDX_W'(id_rt);
        id_entry.rs_used = id_rs_used;
        id_entry.rt_used = id_rt_used;
        if (!id_entry.vld) begin
            id_entry = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sb
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sb_reg[gi] <= '0;
                end else if (gi == 0) begin
                    sb_reg[gi] <= id_entry;
                end else begin
                    sb_reg[gi] <= sb_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    hz_src_match #(
        .STAGES  (STAGES),
        .LOAD_RDY(LOAD_RDY),
        .ALU_RDY (ALU_RDY),
        .SW      (SW)
    ) u_rs_match (
        .sb       (sb_reg),
        .id_src   (IDX_W'(id_rs)),
        .id_used  (id_rs_used),
        .ex_src   (sb_reg[0].rs),
        .ex_used  (sb_reg[0].vld & sb_reg[0].rs_used),
        .stall_req(rs_stall),
        .fwd_sel  (fwd_rs_sel)
    );

    hz_src_match #(
        .STAGES  (STAGES),
        .LOAD_RDY(LOAD_RDY),
        .ALU_RDY (ALU_RDY),
        .SW      (SW)
    ) u_rt_match (
        .sb       (sb_reg),
        .id_src   (IDX_W'(id_rt)),
        .id_used  (id_rt_used),
        .ex_src   (sb_reg[0].rt),
        .ex_used  (sb_reg[0].vld & sb_reg[0].rt_used),
        .stall_req(rt_stall),
        .fwd_sel  (fwd_rt_sel)
    );

    assign stall = id_valid & (rs_stall | rt_stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        hlt          = 1'b0;
        case (state_reg)
            RUN: begin
                // A taken branch wins over both a pending stall and a HLT in ID.
                if (ex_br_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (stall) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (id_valid && id_hlt) begin
                    state_next = DRAIN;
                    cnt_next   = CW'(STAGES);
                end
            end
            DRAIN: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                cnt_next     = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                hlt          = 1'b1;
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

endmodule
